// File: rtl/blur_pkg.sv
// Shared types and defaults for the blur output framing stage.
package blur_pkg;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;

  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic              eof;
    logic [DATA_W-1:0] data;
  } blur_beat_t;

endpackage

// File: rtl/blur_stream_fifo.sv
// Synchronous show-ahead FIFO of blur beats with registered head, valid and level.
module blur_stream_fifo
  import blur_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  blur_beat_t               push_data,
  input  logic                     pop,
  output blur_beat_t               head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  blur_beat_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         level_r;
  blur_beat_t          head_r;
  logic                valid_r;

  logic                pop_ok_s;
  logic                push_ok_s;
  logic [AW-1:0]       rd_nxt_s;
  logic [AW:0]         remain_s;
  logic [AW:0]         level_nxt_s;
  blur_beat_t          head_nxt_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign pop_ok_s  = pop && valid_r && !clr;
  assign push_ok_s = push && !clr && (!full || pop_ok_s);
  assign rd_nxt_s  = rd_ptr_r + AW'(pop_ok_s);
  assign remain_s  = level_r - (AW+1)'(pop_ok_s);

  // Next occupancy and next head; the head may come straight from the write port when nothing older remains.
  always_comb begin
    level_nxt_s = level_r;
    head_nxt_s  = head_r;
    if (clr) begin
      level_nxt_s = '0;
      head_nxt_s  = head_r;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_nxt_s = level_r + (AW+1)'(1);
        2'b01:   level_nxt_s = level_r - (AW+1)'(1);
        default: level_nxt_s = level_r;
      endcase
      if (remain_s != '0) begin
        head_nxt_s = mem[rd_nxt_s];
      end else if (push_ok_s) begin
        head_nxt_s = push_data;
      end else begin
        head_nxt_s = head_r;
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      head_r  <= head_nxt_s;
      valid_r <= (level_nxt_s != '0);
      if (clr) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
        rd_ptr_r <= rd_nxt_s;
      end
    end
  end

  assign head  = head_r;
  assign valid = valid_r;
  assign level = level_r;

endmodule

// File: rtl/blur_out_framer.sv
// Tracks raster position of the blur stream, drops unpopulated border pixels,
// tags frame/line markers and buffers kept pixels for a ready/valid consumer.
module blur_out_framer #(
  parameter int DATA_W     = blur_pkg::DATA_W,
  parameter int IMG_W      = blur_pkg::IMG_W,
  parameter int IMG_H      = blur_pkg::IMG_H,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync_clr,
  input  logic [DATA_W-1:0]             pix_in,
  input  logic                          pix_vld,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_eof,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  import blur_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic          overflow_r;

  logic          sof_s, eol_s, eof_s, keep_s, push_s, drop_s;
  logic          fifo_full_s, fifo_valid_s;
  blur_beat_t    beat_s, head_s;

  assign eol_s  = (col_r == COL_LAST);
  assign eof_s  = eol_s && (row_r == ROW_LAST);
  assign sof_s  = (row_r == RW'(2)) && (col_r == CW'(2));
  assign keep_s = (row_r >= RW'(2)) && (col_r >= CW'(2));
  assign push_s = pix_vld && !sync_clr && keep_s;
  // A push into a full FIFO survives only if the head leaves on the same edge.
  assign drop_s = push_s && fifo_full_s && !(m_ready && fifo_valid_s);

  assign beat_s = '{sof: sof_s, eol: eol_s, eof: eof_s, data: pix_in};

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= '0;
      row_r <= '0;
    end else if (sync_clr) begin
      col_r <= '0;
      row_r <= '0;
    end else if (pix_vld) begin
      if (eol_s) begin
        col_r <= '0;
        row_r <= eof_s ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (sync_clr) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  blur_stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sync_clr),
    .push      (push_s),
    .push_data (beat_s),
    .pop       (m_ready),
    .head      (head_s),
    .valid     (fifo_valid_s),
    .full      (fifo_full_s),
    .level     (fifo_level)
  );

  assign m_data   = head_s.data;
  assign m_sof    = head_s.sof;
  assign m_eol    = head_s.eol;
  assign m_eof    = head_s.eof;
  assign m_valid  = fifo_valid_s;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_blur_out_framer.sv
// Directed self-checking bench for blur_out_framer on an 8x4 image with an 8-entry FIFO.
module tb_blur_out_framer;

  logic       clk = 1'b0;
  logic       rst_n, sync_clr, pix_vld, m_ready;
  logic [7:0] pix_in, m_data;
  logic       m_sof, m_eol, m_eof, m_valid, overflow;
  logic [3:0] fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int drv18;
  int kept_off [12];

  logic [10:0] obs_q[$];
  int          obs_cyc_q[$];

  blur_out_framer #(
    .DATA_W     (8),
    .IMG_W      (8),
    .IMG_H      (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_clr   (sync_clr),
    .pix_in     (pix_in),
    .pix_vld    (pix_vld),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && !sync_clr && m_valid && m_ready) begin
      obs_q.push_back({m_sof, m_eol, m_eof, m_data});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input logic clr = 1'b0);
    @(posedge clk);
    #1;
    pix_in   = v[7:0];
    pix_vld  = 1'b1;
    sync_clr = clr;
  endtask

  task automatic send_range(input int base, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(base + i);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_vld  = 1'b0;
      sync_clr = 1'b0;
    end
  endtask

  function automatic logic [10:0] exp_beat(input int base, input int k);
    logic [7:0] d;
    d = 8'(base + kept_off[k]);
    return {(k == 0), (k == 5 || k == 11), (k == 11), d};
  endfunction

  task automatic check_frame(input string tag, input int base, input int start, input int n);
    for (int k = 0; k < n; k++)
      check_val($sformatf("%s[%0d]", tag, k), obs_q[start + k], exp_beat(base, k));
  endtask

  task automatic settle_count(input string tag, input int n);
    repeat (20) @(negedge clk);
    check_val(tag, obs_q.size(), n);
  endtask

  initial begin
    kept_off = '{18, 19, 20, 21, 22, 23, 26, 27, 28, 29, 30, 31};
    rst_n = 1'b0; sync_clr = 1'b0; pix_vld = 1'b0; m_ready = 1'b1; pix_in = 8'd0;
    drv18 = 0;

    // Reset state
    #12;
    check_val("rst_valid", m_valid, 1'b0);
    check_val("rst_level", fifo_level, 4'd0);
    check_val("rst_ovf", overflow, 1'b0);
    check_val("rst_beat", {m_sof, m_eol, m_eof, m_data}, 11'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Two back-to-back frames with an always-ready consumer
    obs_q.delete(); obs_cyc_q.delete();
    for (int i = 0; i < 32; i++) begin
      send(i);
      if (i == 18) drv18 = cyc;
    end
    send_range(100, 0, 31);
    idle(1);
    settle_count("f12_count", 24);
    check_frame("f1", 0, 0, 12);
    check_frame("f2", 100, 12, 12);
    check_val("f1_latency", obs_cyc_q[0] - drv18, 32'd1);

    // Stalled consumer for a whole frame: saturate, overflow, then drain
    obs_q.delete();
    m_ready = 1'b0;
    send_range(0, 0, 31);
    idle(1);
    @(negedge clk);
    check_val("stall_level", fifo_level, 4'd8);
    check_val("stall_ovf", overflow, 1'b1);
    check_val("stall_valid", m_valid, 1'b1);
    check_val("stall_data0", m_data, 8'd18);
    @(negedge clk);
    check_val("stall_data1", m_data, 8'd18);
    @(posedge clk); #1 m_ready = 1'b1;
    settle_count("drain_count", 8);
    check_frame("drain", 0, 0, 8);
    check_val("drain_level", fifo_level, 4'd0);
    check_val("drain_ovf_sticky", overflow, 1'b1);

    // Resync mid-frame with pix_vld in the same cycle
    obs_q.delete();
    m_ready = 1'b0;
    send_range(0, 0, 19);
    send(99, 1'b1);
    idle(1);
    @(negedge clk);
    check_val("clr_level", fifo_level, 4'd0);
    check_val("clr_valid", m_valid, 1'b0);
    check_val("clr_ovf", overflow, 1'b0);
    m_ready = 1'b1;
    send_range(0, 0, 31);
    idle(1);
    settle_count("clr_count", 12);
    check_frame("clr_frame", 0, 0, 12);

    // Full FIFO with simultaneous pop and push
    obs_q.delete();
    m_ready = 1'b0;
    send_range(0, 0, 27);
    send(28);
    m_ready = 1'b1;
    @(posedge clk); #1;
    pix_vld = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check_val("full_pp_level", fifo_level, 4'd8);
    check_val("full_pp_ovf", overflow, 1'b0);
    check_val("full_pp_head", m_data, 8'd19);
    m_ready = 1'b1;
    settle_count("full_pp_count", 9);
    check_frame("full_pp", 0, 0, 9);

    // Asynchronous reset mid-line with five entries buffered
    send(0, 1'b1);
    idle(1);
    obs_q.delete();
    m_ready = 1'b0;
    send_range(0, 0, 22);
    idle(1);
    @(negedge clk);
    check_val("pre_rst_level", fifo_level, 4'd5);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", m_valid, 1'b0);
    check_val("arst_level", fifo_level, 4'd0);
    check_val("arst_ovf", overflow, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    obs_q.delete();
    m_ready = 1'b1;
    send_range(0, 0, 31);
    idle(1);
    settle_count("post_rst_count", 12);
    check_frame("post_rst", 0, 0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
